// File: rtl/shared_int_mult_bank_if.sv
// Shared integer multiplier bus: two requesting clients, one result return path.
// Ports: req_valid_x / mult_a_x / mult_b_x per client (x = a, b), combinational
//        grant_a / grant_b, registered int_mult_result with res_valid_a / res_valid_b.
interface shared_int_mult_bank_if #(
  parameter int LANES   = 4,
  parameter int OP_BITS = 54
);
  logic                                  req_valid_a;
  logic [LANES-1:0][OP_BITS-1:0]         mult_a_a;
  logic [LANES-1:0][OP_BITS-1:0]         mult_b_a;
  logic                                  req_valid_b;
  logic [LANES-1:0][OP_BITS-1:0]         mult_a_b;
  logic [LANES-1:0][OP_BITS-1:0]         mult_b_b;
  logic                                  grant_a;
  logic                                  grant_b;
  logic [LANES-1:0][2*OP_BITS-1:0]       int_mult_result;
  logic                                  res_valid_a;
  logic                                  res_valid_b;

  // Client side: presents operands, observes grants and tagged results.
  modport master (
    output req_valid_a, mult_a_a, mult_b_a,
    output req_valid_b, mult_a_b, mult_b_b,
    input  grant_a, grant_b,
    input  int_mult_result, res_valid_a, res_valid_b
  );

  // Provider side: the multiplier bank.
  modport slave (
    input  req_valid_a, mult_a_a, mult_b_a,
    input  req_valid_b, mult_a_b, mult_b_b,
    output grant_a, grant_b,
    output int_mult_result, res_valid_a, res_valid_b
  );
endinterface

// File: rtl/shared_int_mult_bank.sv
// Shared multiplier bank: LANES x unsigned OP_BITS*OP_BITS products, time-shared by clients A and B.
// Latency: grant in cycle t -> res_valid_x pulse with product in cycle t+4; one request per cycle.
// Backpressure: refused client holds its request (nothing buffered); A has fixed priority unless
//   SHARED_MULT_ROUND_ROBIN_EN is defined, which alternates grants on conflict via last_owner.
// Ports: clk, rst (async, active-high); bus (slave modport) carries requests, grants, results.
module shared_int_mult_bank #(
  parameter int LANES   = 4,
  parameter int OP_BITS = 54   // must be even
) (
  input  logic                    clk,
  input  logic                    rst,
  shared_int_mult_bank_if.slave   bus
);

  localparam int H = OP_BITS / 2;

  logic grant_a;
  logic grant_b;

  // ---------------------------------------------------------------- arbitration
`ifdef SHARED_MULT_ROUND_ROBIN_EN
  // last_owner: 0 = A, 1 = B. Reset to B so the first conflict goes to A.
  logic last_owner;

  always_comb begin
    grant_a = bus.req_valid_a;
    grant_b = bus.req_valid_b;
    if (bus.req_valid_a && bus.req_valid_b) begin
      grant_a = last_owner;
      grant_b = ~last_owner;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_owner <= 1'b1;
    end else if (grant_a) begin
      last_owner <= 1'b0;
    end else if (grant_b) begin
      last_owner <= 1'b1;
    end
  end
`else
  assign grant_a = bus.req_valid_a;
  assign grant_b = bus.req_valid_b & ~bus.req_valid_a;
`endif

  assign bus.grant_a = grant_a;
  assign bus.grant_b = grant_b;

  // ---------------------------------------------------------------- S0: operand capture
  // Tag owner: 0 = A, 1 = B.
  logic [LANES-1:0][OP_BITS-1:0] s0_a, s0_b;
  logic                          s0_vld, s0_own;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s0_a   <= '0;
      s0_b   <= '0;
      s0_vld <= 1'b0;
      s0_own <= 1'b0;
    end else begin
      s0_vld <= grant_a | grant_b;
      s0_own <= grant_b;
      if (grant_a) begin
        s0_a <= bus.mult_a_a;
        s0_b <= bus.mult_b_a;
      end else if (grant_b) begin
        s0_a <= bus.mult_a_b;
        s0_b <= bus.mult_b_b;
      end
    end
  end

  // ---------------------------------------------------------------- S1: partial products
  // Each half-width product fits in OP_BITS bits, so zero-extending both factors to
  // OP_BITS gives the exact product without a wider intermediate.
  logic [LANES-1:0][OP_BITS-1:0] pp_hh, pp_hl, pp_lh, pp_ll;
  logic [LANES-1:0][OP_BITS-1:0] s1_hh, s1_hl, s1_lh, s1_ll;
  logic                          s1_vld, s1_own;

  always_comb begin
    pp_hh = '0;
    pp_hl = '0;
    pp_lh = '0;
    pp_ll = '0;
    for (int l = 0; l < LANES; l++) begin
      pp_hh[l] = {{H{1'b0}}, s0_a[l][OP_BITS-1:H]} * {{H{1'b0}}, s0_b[l][OP_BITS-1:H]};
      pp_hl[l] = {{H{1'b0}}, s0_a[l][OP_BITS-1:H]} * {{H{1'b0}}, s0_b[l][H-1:0]};
      pp_lh[l] = {{H{1'b0}}, s0_a[l][H-1:0]}       * {{H{1'b0}}, s0_b[l][OP_BITS-1:H]};
      pp_ll[l] = {{H{1'b0}}, s0_a[l][H-1:0]}       * {{H{1'b0}}, s0_b[l][H-1:0]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_hh  <= '0;
      s1_hl  <= '0;
      s1_lh  <= '0;
      s1_ll  <= '0;
      s1_vld <= 1'b0;
      s1_own <= 1'b0;
    end else begin
      s1_vld <= s0_vld;
      s1_own <= s0_own;
      if (s0_vld) begin
        s1_hh <= pp_hh;
        s1_hl <= pp_hl;
        s1_lh <= pp_lh;
        s1_ll <= pp_ll;
      end
    end
  end

  // ---------------------------------------------------------------- S2: cross-term sum
  logic [LANES-1:0][OP_BITS:0]   mid;
  logic [LANES-1:0][OP_BITS:0]   s2_mid;
  logic [LANES-1:0][OP_BITS-1:0] s2_hh, s2_ll;
  logic                          s2_vld, s2_own;

  always_comb begin
    mid = '0;
    for (int l = 0; l < LANES; l++) begin
      mid[l] = {1'b0, s1_hl[l]} + {1'b0, s1_lh[l]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_mid <= '0;
      s2_hh  <= '0;
      s2_ll  <= '0;
      s2_vld <= 1'b0;
      s2_own <= 1'b0;
    end else begin
      s2_vld <= s1_vld;
      s2_own <= s1_own;
      if (s1_vld) begin
        s2_mid <= mid;
        s2_hh  <= s1_hh;
        s2_ll  <= s1_ll;
      end
    end
  end

  // ---------------------------------------------------------------- S3: final assembly
  // hh << OP_BITS plus ll is a plain concatenation since ll < 2^OP_BITS; only the
  // shifted mid term needs a real adder. The true product always fits in 2*OP_BITS.
  logic [LANES-1:0][2*OP_BITS-1:0] prod;
  logic [LANES-1:0][2*OP_BITS-1:0] result_q;
  logic                            vld_a_q, vld_b_q;

  always_comb begin
    prod = '0;
    for (int l = 0; l < LANES; l++) begin
      prod[l] = {s2_hh[l], s2_ll[l]} + {{(H-1){1'b0}}, s2_mid[l], {H{1'b0}}};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result_q <= '0;
      vld_a_q  <= 1'b0;
      vld_b_q  <= 1'b0;
    end else begin
      vld_a_q <= s2_vld & ~s2_own;
      vld_b_q <= s2_vld &  s2_own;
      if (s2_vld) begin
        result_q <= prod;
      end
    end
  end

  assign bus.int_mult_result = result_q;
  assign bus.res_valid_a     = vld_a_q;
  assign bus.res_valid_b     = vld_b_q;

endmodule

// File: tb/tb_shared_int_mult_bank.sv
// Bench for shared_int_mult_bank: directed cases, reset mid-flight and a random soak,
// checked by a scoreboard fed at grant time and drained by an independent result monitor.
module tb_shared_int_mult_bank;

  localparam int LANES   = 4;
  localparam int OP_BITS = 54;
  localparam int RB      = 2 * OP_BITS;

  typedef logic [LANES-1:0][OP_BITS-1:0] ops_t;
  typedef logic [LANES-1:0][RB-1:0]      res_t;
  typedef struct {
    logic own;   // 0 = A, 1 = B
    res_t res;
    int   due;
  } exp_t;

  localparam logic [RB-1:0]      P15    = 108'd15;
  localparam logic [RB-1:0]      PONES  = (108'd1 << 54) - 108'd1;
  localparam logic [RB-1:0]      P2_54  = 108'd1 << 54;
  localparam logic [RB-1:0]      PMAX   = 108'd0 - (108'd1 << 55) + 108'd1;
  localparam logic [OP_BITS-1:0] ONES54 = {OP_BITS{1'b1}};

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  shared_int_mult_bank_if #(.LANES(LANES), .OP_BITS(OP_BITS)) bus();

  shared_int_mult_bank #(.LANES(LANES), .OP_BITS(OP_BITS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  exp_t sb[$];
  logic rr_last = 1'b1;  // reference arbiter memory, used only with round robin

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk1(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0b expected %0b (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chki(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chkw(input string name, input logic [RB-1:0] act, input logic [RB-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chkr(input string name, input res_t act, input res_t exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference product: full-width arithmetic, lane by lane.
  function automatic res_t golden(input ops_t a, input ops_t b);
    res_t r;
    for (int l = 0; l < LANES; l++) begin
      logic [RB-1:0] x, y;
      x = {{OP_BITS{1'b0}}, a[l]};
      y = {{OP_BITS{1'b0}}, b[l]};
      r[l] = x * y;
    end
    return r;
  endfunction

  function automatic logic [OP_BITS-1:0] rnd_op();
    logic [63:0] t;
    case ($urandom_range(0, 9))
      0:       return '0;
      1:       return ONES54;
      default: begin
        t = {$urandom(), $urandom()};
        return t[OP_BITS-1:0];
      end
    endcase
  endfunction

  function automatic ops_t rnd_ops();
    ops_t o;
    for (int l = 0; l < LANES; l++) o[l] = rnd_op();
    return o;
  endfunction

  // One clock of stimulus: drive on the falling edge, check grants against the
  // arbitration rules, queue the expected product for the granted client.
  task automatic step(input logic va, input ops_t aa, input ops_t ab,
                      input logic vb, input ops_t ba, input ops_t bb,
                      output logic ga, output logic gb);
    logic ega, egb;
    @(negedge clk);
    bus.req_valid_a = va;
    bus.mult_a_a    = aa;
    bus.mult_b_a    = ab;
    bus.req_valid_b = vb;
    bus.mult_a_b    = ba;
    bus.mult_b_b    = bb;
    #1;
`ifdef SHARED_MULT_ROUND_ROBIN_EN
    if (va && vb) begin
      ega = rr_last;
      egb = ~rr_last;
    end else begin
      ega = va;
      egb = vb;
    end
    if (ega) rr_last = 1'b0;
    else if (egb) rr_last = 1'b1;
`else
    ega = va;
    egb = vb & ~va;
`endif
    chk1("grant_a", bus.grant_a, ega);
    chk1("grant_b", bus.grant_b, egb);
    if (ega) sb.push_back('{own: 1'b0, res: golden(aa, ab), due: cyc + 4});
    if (egb) sb.push_back('{own: 1'b1, res: golden(ba, bb), due: cyc + 4});
    ga = bus.grant_a;
    gb = bus.grant_b;
    @(posedge clk);
  endtask

  task automatic idle(input int n);
    logic g1, g2;
    ops_t z;
    z = '0;
    repeat (n) step(1'b0, z, z, 1'b0, z, z, g1, g2);
  endtask

  // Result monitor: every valid pulse must match the oldest outstanding grant.
  always @(negedge clk) begin : mon
    exp_t e;
    if (!rst) begin
      if (bus.res_valid_a || bus.res_valid_b) begin
        chk1("one_owner", bus.res_valid_a & bus.res_valid_b, 1'b0);
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_valid: got a=%0b b=%0b expected none (cycle %0d)",
                   bus.res_valid_a, bus.res_valid_b, cyc);
        end else begin
          e = sb.pop_front();
          chk1("owner_b", bus.res_valid_b, e.own);
          chki("latency", cyc, e.due);
          chkr("product", bus.int_mult_result, e.res);
        end
      end else if (sb.size() > 0 && sb[0].due < cyc) begin
        total++;
        bad++;
        $display("FAIL missing_result: got no valid expected one due at cycle %0d (now %0d)",
                 sb[0].due, cyc);
        void'(sb.pop_front());
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: got no completion expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    ops_t oa, ob, z;
    logic ga, gb, va, vb, pa, pb;
    ops_t aa, ab, ba, bb;
    z = '0;
    bus.req_valid_a = 1'b0;
    bus.req_valid_b = 1'b0;
    bus.mult_a_a = '0;
    bus.mult_b_a = '0;
    bus.mult_a_b = '0;
    bus.mult_b_b = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chkr("reset_result", bus.int_mult_result, '0);
    chk1("reset_valid_a", bus.res_valid_a, 1'b0);
    chk1("reset_valid_b", bus.res_valid_b, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    // Single A request with corner operands
    oa[0] = 54'd3;        ob[0] = 54'd5;
    oa[1] = 54'd0;        ob[1] = ONES54;
    oa[2] = 54'd1;        ob[2] = ONES54;
    oa[3] = 54'd1 << 27;  ob[3] = 54'd1 << 27;
    step(1'b1, oa, ob, 1'b0, z, z, ga, gb);
    idle(3);
    #1;
    chk1("single_a_valid_a", bus.res_valid_a, 1'b1);
    chk1("single_a_valid_b", bus.res_valid_b, 1'b0);
    chkw("single_a_lane0", bus.int_mult_result[0], P15);
    chkw("single_a_lane1", bus.int_mult_result[1], '0);
    chkw("single_a_lane2", bus.int_mult_result[2], PONES);
    chkw("single_a_lane3", bus.int_mult_result[3], P2_54);

    // Max operands from B alone
    for (int l = 0; l < LANES; l++) begin
      oa[l] = ONES54;
      ob[l] = ONES54;
    end
    step(1'b0, z, z, 1'b1, oa, ob, ga, gb);
    idle(3);
    #1;
    chk1("max_b_valid_b", bus.res_valid_b, 1'b1);
    chk1("max_b_valid_a", bus.res_valid_a, 1'b0);
    for (int l = 0; l < LANES; l++) chkw("max_b_lane", bus.int_mult_result[l], PMAX);

    // Conflict for 3 cycles, B holding its operands, then A drops
    ba = rnd_ops();
    bb = rnd_ops();
    repeat (3) step(1'b1, rnd_ops(), rnd_ops(), 1'b1, ba, bb, ga, gb);
    step(1'b0, z, z, 1'b1, ba, bb, ga, gb);
    idle(5);

    // 8 back-to-back A requests
    repeat (8) step(1'b1, rnd_ops(), rnd_ops(), 1'b0, z, z, ga, gb);
    idle(6);

    // Reset while results are in flight
    repeat (4) step(1'b1, rnd_ops(), rnd_ops(), 1'b0, z, z, ga, gb);
    #1;
    chk1("pre_reset_valid_a", bus.res_valid_a, 1'b1);
    #1;
    rst = 1'b1;
    bus.req_valid_a = 1'b0;
    bus.req_valid_b = 1'b0;
    sb.delete();
    rr_last = 1'b1;
    #1;
    chkr("midreset_result", bus.int_mult_result, '0);
    chk1("midreset_valid_a", bus.res_valid_a, 1'b0);
    chk1("midreset_valid_b", bus.res_valid_b, 1'b0);
    @(posedge clk);
    #2;
    rst = 1'b0;
    idle(6);
    step(1'b1, rnd_ops(), rnd_ops(), 1'b0, z, z, ga, gb);
    idle(5);

    // Random soak; a refused client holds its request and operands
    pa = 1'b0;
    pb = 1'b0;
    va = 1'b0;
    vb = 1'b0;
    aa = z; ab = z; ba = z; bb = z;
    for (int i = 0; i < 10000; i++) begin
      if (!pa) begin
        va = ($urandom_range(0, 1) == 1);
        aa = rnd_ops();
        ab = rnd_ops();
      end
      if (!pb) begin
        vb = ($urandom_range(0, 2) != 0);
        ba = rnd_ops();
        bb = rnd_ops();
      end
      step(va, aa, ab, vb, ba, bb, ga, gb);
      pa = va & ~ga;
      pb = vb & ~gb;
    end
    idle(8);
    chki("drained", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
